// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package ifetch_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned WORD_BYTES = 4;

    localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_HALT
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
    } if_id_t;

    // Sequential next-word address, wraps modulo 2^32.
    function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
        return pc + XLEN'(WORD_BYTES);
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: instruction memory port, redirect input and IF/ID handshake.
interface instr_fetch_if;
    import ifetch_pkg::*;

    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_instr;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_instr;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_pc_plus4;

    modport master (
        output imem_addr, out_valid, out_instr, out_pc, out_pc_plus4,
        input  imem_instr, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  imem_addr, out_valid, out_instr, out_pc, out_pc_plus4,
        output imem_instr, redirect_valid, redirect_pc, out_ready
    );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with valid/ready handshake toward decode.
module if_id_reg
    import ifetch_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   load,
    input  logic   flush,
    input  logic   ready,
    input  if_id_t load_data,
    output logic   valid,
    output if_id_t data
);

    // Flush wins over load; an emptied slot always shows the NOP word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '{instr: NOP_INSTR, pc: '0, pc_plus4: '0};
        end else if (flush) begin
            valid      <= 1'b0;
            data.instr <= NOP_INSTR;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (valid && ready) begin
            valid      <= 1'b0;
            data.instr <= NOP_INSTR;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, reads instruction memory, feeds the IF/ID register.
// Optional IFETCH_ALIGN_CHECK_EN refuses word-misaligned redirects and flags misalign_fault.
module instr_fetch
    import ifetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned     MEM_BYTES = 256,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    instr_fetch_if.master    bus,
    output logic             halted,
    output logic [XLEN-1:0]  fetch_count
`ifdef IFETCH_ALIGN_CHECK_EN
    ,
    output logic             misalign_fault
`endif
);

    localparam logic [XLEN-1:0] LAST_WORD_PC = XLEN'(MEM_BYTES - WORD_BYTES);

    fetch_state_t    state;
    logic [XLEN-1:0] pc;

    logic   in_range_c;
    logic   redirect_c;
    logic   redirect_ok_c;
    logic   load_c;
    if_id_t load_data_c;
    if_id_t if_id_q;

    assign in_range_c = (pc <= LAST_WORD_PC);
    assign redirect_c = bus.redirect_valid && (state != S_BOOT);

`ifdef IFETCH_ALIGN_CHECK_EN
    assign redirect_ok_c = (bus.redirect_pc[1:0] == 2'b00);
`else
    assign redirect_ok_c = 1'b1;
`endif

    assign load_c = (state == S_RUN) && !redirect_c && in_range_c
                    && (!bus.out_valid || bus.out_ready);

    assign load_data_c = '{instr: bus.imem_instr, pc: pc, pc_plus4: pc_next(pc)};

    assign bus.imem_addr    = pc;
    assign bus.out_instr    = if_id_q.instr;
    assign bus.out_pc       = if_id_q.pc;
    assign bus.out_pc_plus4 = if_id_q.pc_plus4;

    // PC / state machine; halted tracks entry into and exit from S_HALT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_BOOT;
            pc          <= RESET_PC;
            halted      <= 1'b0;
            fetch_count <= '0;
        end else begin
            case (state)
                S_BOOT: state <= S_RUN;
                S_RUN, S_HALT: begin
                    if (redirect_c) begin
                        if (redirect_ok_c) begin
                            pc     <= bus.redirect_pc;
                            state  <= S_RUN;
                            halted <= 1'b0;
                        end else begin
                            state  <= S_HALT;
                            halted <= 1'b1;
                        end
                    end else if (state == S_RUN) begin
                        if (!in_range_c) begin
                            state  <= S_HALT;
                            halted <= 1'b1;
                        end else if (load_c) begin
                            pc          <= pc_next(pc);
                            fetch_count <= fetch_count + XLEN'(1);
                        end
                    end
                end
                default: state <= S_BOOT;
            endcase
        end
    end

`ifdef IFETCH_ALIGN_CHECK_EN
    // Sticky until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_fault <= 1'b0;
        end else if (redirect_c && !redirect_ok_c) begin
            misalign_fault <= 1'b1;
        end
    end
`endif

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load_c),
        .flush     (redirect_c),
        .ready     (bus.out_ready),
        .load_data (load_data_c),
        .valid     (bus.out_valid),
        .data      (if_id_q)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed table, hand sequences, random vs. reference model.
module tb_instr_fetch;
    import ifetch_pkg::*;

    localparam int unsigned MEM_BYTES = 256;
    localparam logic [31:0] NOP       = 32'h0000_0000;
    localparam logic [31:0] LAST_PC   = 32'(MEM_BYTES - 4);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        halted;
    logic [31:0] fetch_count;
`ifdef IFETCH_ALIGN_CHECK_EN
    logic        misalign_fault;
`endif

    instr_fetch_if bus();

    instr_fetch #(
        .RESET_PC  (32'h0000_0000),
        .MEM_BYTES (MEM_BYTES),
        .NOP_INSTR (NOP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .halted      (halted),
        .fetch_count (fetch_count)
`ifdef IFETCH_ALIGN_CHECK_EN
        ,
        .misalign_fault (misalign_fault)
`endif
    );

    always #5 clk = ~clk;

    logic [31:0] mem [64];
    assign bus.imem_instr = mem[bus.imem_addr[7:2]];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: architectural view of the fetch stage.
    logic        m_boot, m_halt, m_valid;
    logic [31:0] m_pc, m_instr, m_opc, m_cnt;
`ifdef IFETCH_ALIGN_CHECK_EN
    logic        m_fault;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_boot  = 1'b1;
        m_halt  = 1'b0;
        m_valid = 1'b0;
        m_pc    = 32'h0;
        m_instr = NOP;
        m_opc   = 32'h0;
        m_cnt   = 32'h0;
`ifdef IFETCH_ALIGN_CHECK_EN
        m_fault = 1'b0;
`endif
    endtask

    task automatic m_step();
        logic xfer;
        logic load;
        xfer = m_valid && bus.out_ready;
        if (m_boot) begin
            m_boot = 1'b0;
            return;
        end
        if (bus.redirect_valid) begin
            m_valid = 1'b0;
            m_instr = NOP;
`ifdef IFETCH_ALIGN_CHECK_EN
            if (bus.redirect_pc[1:0] != 2'b00) begin
                m_fault = 1'b1;
                m_halt  = 1'b1;
                return;
            end
`endif
            m_pc   = bus.redirect_pc;
            m_halt = 1'b0;
            return;
        end
        load = !m_halt && (m_pc <= LAST_PC) && (!m_valid || bus.out_ready);
        if (!m_halt && (m_pc > LAST_PC)) m_halt = 1'b1;
        if (load) begin
            m_valid = 1'b1;
            m_instr = mem[m_pc[7:2]];
            m_opc   = m_pc;
            m_pc    = m_pc + 32'd4;
            m_cnt   = m_cnt + 32'd1;
        end else if (xfer) begin
            m_valid = 1'b0;
            m_instr = NOP;
        end
    endtask

    task automatic check_model();
        chk("valid", 32'(bus.out_valid), 32'(m_valid));
        chk("instr", bus.out_instr, m_instr);
        chk("imem_addr", bus.imem_addr, m_pc);
        chk("halted", 32'(halted), 32'(m_halt));
        chk("fetch_count", fetch_count, m_cnt);
        if (m_valid) begin
            chk("out_pc", bus.out_pc, m_opc);
            chk("out_pc_plus4", bus.out_pc_plus4, m_opc + 32'd4);
        end
`ifdef IFETCH_ALIGN_CHECK_EN
        chk("misalign_fault", 32'(misalign_fault), 32'(m_fault));
`endif
    endtask

    task automatic tick();
        m_step();
        @(posedge clk);
        #1;
        check_model();
    endtask

    typedef struct {
        logic        redir;
        logic [31:0] rpc;
        logic        ready;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_addr;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vt [12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic        found;
        logic [31:0] saved_addr;

        mem[0] = 32'h8C08_0005;
        for (int i = 1; i < 64; i++) mem[i] = $urandom;

        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.out_ready      = 1'b0;
        m_reset();

        // Reset values while rst_n is held low.
        #2;
        chk("rst_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_instr", bus.out_instr, NOP);
        chk("rst_out_pc", bus.out_pc, 32'h0);
        chk("rst_out_pc4", bus.out_pc_plus4, 32'h0);
        chk("rst_addr", bus.imem_addr, 32'h0);
        chk("rst_count", fetch_count, 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        #6;
        rst_n = 1'b1;

        // redir, rpc, ready, exp valid, exp out_pc, exp imem_addr, exp fetch_count
        vt[0]  = '{1'b0, 32'h00, 1'b1, 1'b0, 32'h00, 32'h00, 32'd0};
        vt[1]  = '{1'b0, 32'h00, 1'b1, 1'b1, 32'h00, 32'h04, 32'd1};
        vt[2]  = '{1'b0, 32'h00, 1'b1, 1'b1, 32'h04, 32'h08, 32'd2};
        vt[3]  = '{1'b0, 32'h00, 1'b1, 1'b1, 32'h08, 32'h0C, 32'd3};
        vt[4]  = '{1'b0, 32'h00, 1'b0, 1'b1, 32'h08, 32'h0C, 32'd3};
        vt[5]  = '{1'b0, 32'h00, 1'b0, 1'b1, 32'h08, 32'h0C, 32'd3};
        vt[6]  = '{1'b0, 32'h00, 1'b0, 1'b1, 32'h08, 32'h0C, 32'd3};
        vt[7]  = '{1'b0, 32'h00, 1'b1, 1'b1, 32'h0C, 32'h10, 32'd4};
        vt[8]  = '{1'b0, 32'h00, 1'b1, 1'b1, 32'h10, 32'h14, 32'd5};
        vt[9]  = '{1'b0, 32'h00, 1'b1, 1'b1, 32'h14, 32'h18, 32'd6};
        vt[10] = '{1'b1, 32'h18, 1'b1, 1'b0, 32'h00, 32'h18, 32'd6};
        vt[11] = '{1'b0, 32'h00, 1'b1, 1'b1, 32'h18, 32'h1C, 32'd7};

        for (int i = 0; i < 12; i++) begin
            bus.redirect_valid = vt[i].redir;
            bus.redirect_pc    = vt[i].rpc;
            bus.out_ready      = vt[i].ready;
            tick();
            chk("tbl_valid", 32'(bus.out_valid), 32'(vt[i].e_valid));
            chk("tbl_addr", bus.imem_addr, vt[i].e_addr);
            chk("tbl_count", fetch_count, vt[i].e_cnt);
            if (vt[i].e_valid) begin
                chk("tbl_out_pc", bus.out_pc, vt[i].e_pc);
                chk("tbl_instr", bus.out_instr, mem[vt[i].e_pc[7:2]]);
            end else begin
                chk("tbl_nop", bus.out_instr, NOP);
            end
            if (i == 1) chk("first_instr", bus.out_instr, 32'h8C08_0005);
        end

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            bus.out_ready      = ($urandom_range(0, 3) != 0);
            bus.redirect_valid = ($urandom_range(0, 15) == 0);
            bus.redirect_pc    = 32'($urandom_range(0, 66)) << 2;
            tick();
        end
        bus.redirect_valid = 1'b0;

        // Run off the end of memory, hold the last word, then drain.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'd248;
        bus.out_ready      = 1'b1;
        tick();
        bus.redirect_valid = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            tick();
            if (bus.out_valid && bus.out_pc == LAST_PC) found = 1'b1;
        end
        chk("reach_last_word", 32'(found), 32'h1);
        bus.out_ready = 1'b0;
        tick();
        chk("halt_flag", 32'(halted), 32'h1);
        chk("halt_hold_valid", 32'(bus.out_valid), 32'h1);
        chk("halt_hold_pc", bus.out_pc, LAST_PC);
        tick();
        bus.out_ready = 1'b1;
        tick();
        chk("halt_drained", 32'(bus.out_valid), 32'h0);
        chk("halt_stays", 32'(halted), 32'h1);
        tick();
        chk("halt_no_load", 32'(bus.out_valid), 32'h0);

        // Redirect out of halt resumes at 0.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0;
        tick();
        bus.redirect_valid = 1'b0;
        chk("resume_halted", 32'(halted), 32'h0);
        chk("resume_addr", bus.imem_addr, 32'h0);
        tick();
        chk("resume_pc", bus.out_pc, 32'h0);
        chk("resume_valid", 32'(bus.out_valid), 32'h1);

        // Asynchronous reset in the middle of a stall.
        bus.out_ready = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.out_valid), 32'h0);
        chk("arst_instr", bus.out_instr, NOP);
        chk("arst_addr", bus.imem_addr, 32'h0);
        chk("arst_count", fetch_count, 32'h0);
        chk("arst_halted", 32'(halted), 32'h0);
        m_reset();
        #2;
        rst_n = 1'b1;

        // Redirect during the boot cycle is ignored.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h40;
        bus.out_ready      = 1'b1;
        tick();
        bus.redirect_valid = 1'b0;
        chk("boot_redirect_ignored", bus.imem_addr, 32'h0);
        tick();
        tick();
        chk("post_boot_pc", bus.out_pc, 32'h4);

        // Misaligned redirect target.
        saved_addr         = bus.imem_addr;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h6;
        tick();
        bus.redirect_valid = 1'b0;
        chk("misalign_valid", 32'(bus.out_valid), 32'h0);
`ifdef IFETCH_ALIGN_CHECK_EN
        chk("misalign_fault_set", 32'(misalign_fault), 32'h1);
        chk("misalign_halted", 32'(halted), 32'h1);
        chk("misalign_pc_kept", bus.imem_addr, saved_addr);
        tick();
        chk("misalign_sticky", 32'(misalign_fault), 32'h1);
        chk("misalign_no_load", 32'(bus.out_valid), 32'h0);
`else
        chk("unaligned_addr", bus.imem_addr, 32'h6);
        chk("unaligned_halted", 32'(halted), 32'h0);
        tick();
        chk("unaligned_out_pc", bus.out_pc, 32'h6);
        chk("unaligned_instr", bus.out_instr, mem[1]);
        chk("unaligned_next", bus.imem_addr, 32'hA);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage directly upstream of the instruction memory. Owns the program counter and drives the memory's 32-bit byte read address.
- Captures the 32-bit word the memory returns combinationally into an IF/ID output register, with a valid/ready handshake toward decode.
- Accepts PC redirects from branch/jump resolution (e.g. BEQ target).

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- MEM_BYTES, 256, instruction memory size in bytes; the last full word starts at MEM_BYTES-4.
- NOP_INSTR, 32'h0000_0000, value driven on out_instr when not valid.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_addr  out  32  byte address to instruction memory; always equals pc.
- imem_instr  in  32  word returned combinationally by instruction memory for imem_addr.
- redirect_valid  in  1  redirect request from branch/jump unit, one-cycle pulse.
- redirect_pc  in  32  redirect target byte address.
- out_valid  out  1  IF/ID register holds a valid instruction.
- out_ready  in  1  decode accepts the instruction this cycle.
- out_instr  out  32  fetched instruction.
- out_pc  out  32  address of out_instr.
- out_pc_plus4  out  32  out_pc + 4, modulo 2^32.
- halted  out  1  high while in S_HALT.
- fetch_count  out  32  number of instructions loaded into IF/ID since reset; wraps at 2^32.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: pc=RESET_PC, state=S_BOOT, out_valid=0, out_instr=NOP_INSTR, out_pc=0, out_pc_plus4=0, fetch_count=0, halted=0.
- imem_addr = pc, combinational. No memory latency: imem_instr is valid in the same cycle.
- States and transitions:
  - S_BOOT: one cycle after reset release, no load. Moves to S_RUN unconditionally.
  - S_RUN: fetch when load = (!out_valid || out_ready).
  - S_HALT: no loads. halted=1. Exits to S_RUN only on redirect.
- Load in S_RUN: out_instr<=imem_instr, out_pc<=pc, out_pc_plus4<=pc+4, out_valid<=1, pc<=pc+4, fetch_count++.
- Halt condition: in S_RUN, if pc > MEM_BYTES-4 (no full word at pc), do not load and go to S_HALT. An out_valid already held still drains via out_ready.
- Handshake:
  - Transfer occurs when out_valid && out_ready.
  - With out_valid=1 and out_ready=0, the register and pc hold (stall).
  - With no new load, a transfer clears out_valid.
  - Back-to-back: transfer and load in the same cycle gives one instruction per cycle.
- Redirect (highest priority, any state except S_BOOT):
  - Next cycle: pc<=redirect_pc, out_valid<=0, out_instr<=NOP_INSTR, state<=S_RUN, no load, fetch_count unchanged.
  - A transfer occurring in the redirect cycle still completes; decode owns that instruction.
  - Redirect in S_BOOT is ignored.
- PC arithmetic is 32-bit unsigned with wrap. pc+4 from 32'hFFFF_FFFC gives 0; halt logic then applies normally.
- out_instr is NOP_INSTR whenever out_valid=0.
- Reset mid-operation: immediate return to reset values. In-flight instruction discarded.

Optional Feature:
- Macro: IFETCH_ALIGN_CHECK_EN.
- Defined:
  - Adds output port misalign_fault (1 bit, reset 0).
  - A redirect with redirect_pc[1:0]!=0 is not taken: pc unchanged, state goes to S_HALT, misalign_fault<=1 (sticky until reset).
  - out_valid is still cleared.
- Undefined:
  - No port.
  - redirect_pc is loaded as-is; fetch proceeds from the unaligned byte address.

Decomposition:
- Package ifetch_pkg:
  - fetch_state_t enum {S_BOOT, S_RUN, S_HALT}.
  - WORD_BYTES=4.
  - Default NOP_INSTR constant.
  - Struct if_id_t {instr, pc, pc_plus4}.
- One natural sub-module: if_id_reg, holding the valid/ready output register. PC/FSM stays in instr_fetch.

Test Plan:
- Reset then out_ready=1 with memory preloaded at 0..20 → out_pc 0,4,8,12,16,20 on consecutive cycles after S_BOOT. out_instr=32'h8C080005 at pc 0. fetch_count=6.
- out_ready=0 for 3 cycles at out_pc=8 → out_instr/out_pc/imem_addr (=12) held. Release gives pc 12 next cycle, no skip or duplicate.
- redirect_valid pulse with redirect_pc=32'h18 while out_valid=1 and out_ready=1 → current instruction transferred. Next cycle out_valid=0. Following cycle out_pc=32'h18.
- Run to pc=252 with MEM_BYTES=256 → word at 252 delivered, then halted=1 and out_valid drops after drain. Redirect to 0 resumes fetch.
- Assert rst_n=0 mid-stall → outputs return to reset values asynchronously, without waiting for a clock edge.
- With IFETCH_ALIGN_CHECK_EN: redirect_pc=32'h6 → misalign_fault=1, halted=1, pc unchanged. Without it: imem_addr=6 on the next cycle.
